pvt_freq_counter: RTL
=====================

Name: pvt_freq_counter

Overview:
- Downstream consumer of the divided ring-oscillator outputs (inverter-ring and NAND2-ring, each already divided by 16).
- Counts rising edges of each oscillator over a fixed window of `clk` cycles and reports the count per channel through a valid/ready result port.
- Sequences channel 0 then channel 1, in single-shot or continuous mode.
- Its output feeds the on-chip readout mux in place of off-chip frequency measurement.

Parameters:
- GATE_LOG2, 10, gate window length is 2^GATE_LOG2 `clk` cycles.
- CNT_W, 16, result counter width.
- SYNC_STAGES, 2, synchronizer flops per oscillator input (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; begins a measurement sequence when idle.
- continuous  input  1  level; when high, the sequence repeats after channel 1 is accepted.
- osc_in  input  2  asynchronous divided oscillator clocks; bit 0 = inverter ring, bit 1 = NAND2 ring.
- result_data  output  CNT_W  edge count for the reported channel.
- result_ch  output  1  channel index of result_data.
- result_sat  output  1  count saturated during the window.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, channel=0, counter=0.
  - result_data=0, result_ch=0, result_sat=0, result_valid=0, busy=0.
  - Reset in any state, including mid-window, aborts the sequence with no partial result.
- Input conditioning:
  - Each osc_in bit passes through SYNC_STAGES flops plus one history flop; these run continuously.
  - A rising edge is flagged when sync_out=1 and history=0 (a single-cycle pulse).
  - Inputs must be below clk/2 after division. Higher rates alias and are outside the specification.
- States:
  - IDLE: wait for start.
    - start=1 → ARM with channel=0.
    - start while not in IDLE is ignored.
  - ARM: one cycle. Clears the counter, sat flag and gate counter.
    - → COUNT.
  - COUNT: exactly 2^GATE_LOG2 cycles.
    - Each cycle with an edge pulse on the selected channel increments the counter.
    - An edge in the first and in the last COUNT cycle is counted; edges in ARM and REPORT are not.
    - The counter saturates at all-ones and sets sat; it does not wrap.
    - After the last cycle → REPORT, loading result_data, result_ch and result_sat and asserting result_valid on the next cycle.
  - REPORT: result_valid held high. result_data, result_ch and result_sat stay stable until the handshake.
    - Handshake = result_valid & result_ready at a clk edge.
    - On handshake with channel=0 → ARM with channel=1.
    - On handshake with channel=1:
      - continuous=1 → ARM with channel=0;
      - otherwise → IDLE.
    - result_valid deasserts in the cycle after the handshake.
- Result registers keep their last values after valid drops; they are only cleared by reset.
- No measurement proceeds while a result is pending, so there is no overflow or drop condition.
- continuous is sampled only at the channel-1 handshake.

Decomposition:
- Package pvt_mon_pkg:
  - state enum typedef (IDLE, ARM, COUNT, REPORT);
  - localparam NUM_OSC_CH=2;
  - channel index typedef.
- Sub-module osc_edge_sync: parameterised synchronizer plus rising-edge detector, instantiated once per channel.
- The gate counter is GATE_LOG2+1 bits wide so that terminal count is detected cleanly.

Test Plan (GATE_LOG2=4 → 16-cycle window unless noted):
- osc_in[0] period 4 clk and osc_in[1] period 8 clk, start pulse, ready tied high → results (ch0, 4, sat=0) then (ch1, 2, sat=0); busy drops one cycle after the second handshake.
- CNT_W=2, osc_in[0] period 2 clk → result_data=3, result_sat=1; the ch1 result is unaffected.
- ready held low for 10 cycles in REPORT → result_valid stays high, data is stable, no ARM occurs; ready=1 → ch1 ARM on the next cycle.
- continuous=1, ready high → ch0, ch1, ch0, ch1 results in strict order with equal counts per channel.
- rst asserted at cycle 8 of COUNT → all outputs 0 next cycle, state IDLE; a new start yields a correct full-window count.
- start pulsed during COUNT and REPORT → ignored; exactly two results are produced per single-shot sequence.

Source files
------------

// File: rtl/pvt_mon_pkg.sv
// Shared types for the PVT ring-oscillator frequency counter.
// Holds the FSM state enum, the channel count and the channel index type.
package pvt_mon_pkg;

  localparam int NUM_OSC_CH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_REPORT
  } state_t;

  typedef logic [$clog2(NUM_OSC_CH)-1:0] ch_t;

endpackage

// File: rtl/osc_edge_sync.sv
// Synchronizer chain plus history flop; flags one-cycle rising-edge pulses.
// Ports: clk, i_osc (async level in), o_rise (single-cycle edge pulse).
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_osc,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Free-running: no reset, so edges are tracked through rst too.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_osc};
    r_hist <= r_sync[SYNC_STAGES-1];
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/pvt_freq_counter.sv
// Gated edge counter for two divided ring oscillators, ch0 then ch1.
// Ports: clk, rst, start, continuous, osc_in[1:0], result_* (valid/ready), busy.
module pvt_freq_counter
  import pvt_mon_pkg::*;
#(
  parameter int GATE_LOG2   = 10,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [NUM_OSC_CH-1:0] osc_in,
  output logic [CNT_W-1:0]      result_data,
  output logic                  result_ch,
  output logic                  result_sat,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  logic [NUM_OSC_CH-1:0] w_rise;

  for (genvar g = 0; g < NUM_OSC_CH; g++) begin : g_sync
    osc_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .i_osc (osc_in[g]),
      .o_rise(w_rise[g])
    );
  end

  state_t             r_state;
  state_t             w_state_nxt;
  ch_t                r_ch;
  logic [GATE_LOG2:0] r_gate;
  logic [GATE_LOG2:0] w_gate_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_sat;
  logic               w_sat_nxt;
  logic [CNT_W-1:0]   r_data;
  logic               r_rch;
  logic               r_rsat;
  logic               r_valid;
  logic               w_edge;
  logic               w_last;
  logic               w_hs;
  logic               w_ch_last;

  assign w_edge     = w_rise[r_ch];
  assign w_gate_nxt = r_gate + 1'b1;
  // Extra gate bit: its rise on the next value marks the final COUNT cycle.
  assign w_last     = (r_state == ST_COUNT) & w_gate_nxt[GATE_LOG2];
  assign w_hs       = r_valid & result_ready;
  assign w_ch_last  = (r_ch == ch_t'(NUM_OSC_CH - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (w_edge) begin
      if (&r_cnt) w_sat_nxt = 1'b1;
      else        w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_ARM;
      ST_ARM:    w_state_nxt = ST_COUNT;
      ST_COUNT:  if (w_last) w_state_nxt = ST_REPORT;
      ST_REPORT: begin
        if (w_hs) begin
          if (!w_ch_last || continuous) w_state_nxt = ST_ARM;
          else                          w_state_nxt = ST_IDLE;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch    <= '0;
      r_gate  <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_data  <= '0;
      r_rch   <= 1'b0;
      r_rsat  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) r_ch <= '0;
        ST_ARM: begin
          r_cnt  <= '0;
          r_sat  <= 1'b0;
          r_gate <= '0;
        end
        ST_COUNT: begin
          r_cnt  <= w_cnt_nxt;
          r_sat  <= w_sat_nxt;
          r_gate <= w_gate_nxt;
          if (w_last) begin
            r_data  <= w_cnt_nxt;
            r_rch   <= r_ch;
            r_rsat  <= w_sat_nxt;
            r_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            // ch1 wraps to ch0, covering both continuous and IDLE exits.
            r_ch    <= w_ch_last ? '0 : r_ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_data  = r_data;
  assign result_ch    = r_rch;
  assign result_sat   = r_rsat;
  assign result_valid = r_valid;
  assign busy         = (r_state != ST_IDLE);

endmodule
